// File: rtl/tri_span_array.sv
// rtl/tri_span_array.sv - Multi-channel scanline triangle span rasteriser with Wishbone setup registers
// Ports:
//   wb_clk_i, wb_rst_ni        sole clock, asynchronous active-low reset
//   wbs_cyc_i .. wbs_dat_o     Wishbone slave; adr[4:2] selects the word, upper bits the triangle.
//                              Words 0-4 are configuration, word 5 is live accumulators, words 6-7 read zero.
//   frame_start, line_step     raster controls (frame_start wins when both are high)
//   y_o                        current scanline
//   span_valid, x_start, x_end per-channel span, X fields packed COORD_W bits per channel
module tri_span_array #(
    parameter int NUM_TRI = 4,
    parameter int COORD_W = 8,
    parameter int FRAC_W  = 8
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_ni,
    input  logic                       wbs_cyc_i,
    input  logic                       wbs_stb_i,
    input  logic                       wbs_we_i,
    input  logic [3:0]                 wbs_sel_i,
    input  logic [$clog2(NUM_TRI)+4:0] wbs_adr_i,
    input  logic [31:0]                wbs_dat_i,
    output logic                       wbs_ack_o,
    output logic [31:0]                wbs_dat_o,
    input  logic                       frame_start,
    input  logic                       line_step,
    output logic [COORD_W-1:0]         y_o,
    output logic [NUM_TRI-1:0]         span_valid,
    output logic [NUM_TRI*COORD_W-1:0] x_start,
    output logic [NUM_TRI*COORD_W-1:0] x_end
);

    localparam int AW = COORD_W + FRAC_W;

    logic [COORD_W-1:0] y_top     [NUM_TRI];
    logic [COORD_W-1:0] y_mid     [NUM_TRI];
    logic [COORD_W-1:0] y_bot     [NUM_TRI];
    logic [AW-1:0]      xl_init   [NUM_TRI];
    logic [AW-1:0]      xr_init   [NUM_TRI];
    logic [AW-1:0]      slope_l   [NUM_TRI];
    logic [AW-1:0]      slope_r   [NUM_TRI];
    logic [AW-1:0]      slope_bot [NUM_TRI];
    logic [AW-1:0]      xl_acc    [NUM_TRI];
    logic [AW-1:0]      xr_acc    [NUM_TRI];
    logic [NUM_TRI-1:0] en;
    logic [NUM_TRI-1:0] side;
    logic [COORD_W-1:0] y_q;

    logic [31:0]        tri_sel;
    logic [2:0]         word_sel;
    logic               bus_req;
    logic [31:0]        rd_word;
    logic [31:0]        wr_word;
    logic [NUM_TRI-1:0] step_en;
    logic [NUM_TRI-1:0] upper;
    logic               unused_adr;

    assign tri_sel    = 32'(wbs_adr_i >> 5);
    assign word_sel   = wbs_adr_i[4:2];
    assign unused_adr = ^wbs_adr_i[1:0];
    // A request is taken only while ack is low, so a held strobe is acked every other cycle.
    assign bus_req    = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;

    // Register image of the addressed word; out-of-range triangles match no channel and read 0.
    always_comb begin
        rd_word = '0;
        for (int t = 0; t < NUM_TRI; t++) begin
            if (tri_sel == 32'(t)) begin
                case (word_sel)
                    3'd0:    rd_word = {16'(y_mid[t]), 16'(y_top[t])};
                    3'd1:    rd_word = {14'd0, side[t], en[t], 16'(y_bot[t])};
                    3'd2:    rd_word = {16'(xr_init[t]), 16'(xl_init[t])};
                    3'd3:    rd_word = {16'(slope_r[t]), 16'(slope_l[t])};
                    3'd4:    rd_word = {16'd0, 16'(slope_bot[t])};
                    3'd5:    rd_word = {16'(xr_acc[t]), 16'(xl_acc[t])};
                    default: rd_word = '0;
                endcase
            end
        end
    end

    // Byte-lane merge of write data over the current image so unselected bytes keep their value.
    always_comb begin
        wr_word = '0;
        for (int b = 0; b < 4; b++) begin
            wr_word[8*b +: 8] = wbs_sel_i[b] ? wbs_dat_i[8*b +: 8] : rd_word[8*b +: 8];
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            en        <= '0;
            side      <= '0;
            for (int t = 0; t < NUM_TRI; t++) begin
                y_top[t]     <= '0;
                y_mid[t]     <= '0;
                y_bot[t]     <= '0;
                xl_init[t]   <= '0;
                xr_init[t]   <= '0;
                slope_l[t]   <= '0;
                slope_r[t]   <= '0;
                slope_bot[t] <= '0;
            end
        end else begin
            wbs_ack_o <= bus_req;
            if (bus_req && !wbs_we_i) begin
                wbs_dat_o <= rd_word;
            end
            for (int t = 0; t < NUM_TRI; t++) begin
                if (bus_req && wbs_we_i && tri_sel == 32'(t)) begin
                    case (word_sel)
                        3'd0: begin
                            y_top[t] <= wr_word[COORD_W-1:0];
                            y_mid[t] <= wr_word[16 +: COORD_W];
                        end
                        3'd1: begin
                            y_bot[t] <= wr_word[COORD_W-1:0];
                            en[t]    <= wr_word[16];
                            side[t]  <= wr_word[17];
                        end
                        3'd2: begin
                            xl_init[t] <= wr_word[AW-1:0];
                            xr_init[t] <= wr_word[16 +: AW];
                        end
                        3'd3: begin
                            slope_l[t] <= wr_word[AW-1:0];
                            slope_r[t] <= wr_word[16 +: AW];
                        end
                        3'd4:    slope_bot[t] <= wr_word[AW-1:0];
                        default: ;
                    endcase
                end
            end
        end
    end

    // A channel steps on lines [y_top, y_bot); below y_mid the side-selected edge uses slope_bot.
    always_comb begin
        step_en = '0;
        upper   = '0;
        for (int t = 0; t < NUM_TRI; t++) begin
            step_en[t] = en[t] && (y_top[t] <= y_q) && (y_q < y_bot[t]);
            upper[t]   = y_q < y_mid[t];
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            y_q <= '0;
            for (int t = 0; t < NUM_TRI; t++) begin
                xl_acc[t] <= '0;
                xr_acc[t] <= '0;
            end
        end else if (frame_start) begin
            y_q <= '0;
            for (int t = 0; t < NUM_TRI; t++) begin
                xl_acc[t] <= xl_init[t];
                xr_acc[t] <= xr_init[t];
            end
        end else if (line_step) begin
            y_q <= y_q + COORD_W'(1);
            for (int t = 0; t < NUM_TRI; t++) begin
                if (step_en[t]) begin
                    xl_acc[t] <= xl_acc[t] + ((upper[t] || side[t])  ? slope_l[t] : slope_bot[t]);
                    xr_acc[t] <= xr_acc[t] + ((upper[t] || !side[t]) ? slope_r[t] : slope_bot[t]);
                end
            end
        end
    end

    assign y_o = y_q;

    always_comb begin
        span_valid = '0;
        x_start    = '0;
        x_end      = '0;
        for (int t = 0; t < NUM_TRI; t++) begin
            span_valid[t]                 = en[t] && (y_top[t] <= y_q) && (y_q <= y_bot[t]);
            x_start[t*COORD_W +: COORD_W] = xl_acc[t][FRAC_W +: COORD_W];
            x_end[t*COORD_W +: COORD_W]   = xr_acc[t][FRAC_W +: COORD_W];
        end
    end

endmodule

// File: tb/tb_tri_span_array.sv
// tb/tb_tri_span_array.sv - Self-checking bench for tri_span_array
module tb_tri_span_array;

    logic        clk, rst_n, cyc, stb, we, use5, frame_start, line_step, zero;
    logic [3:0]  sel;
    logic [7:0]  adr;
    logic [31:0] dat;
    logic        ack4, ack5;
    logic [31:0] dat4, dat5;
    logic [7:0]  y_o, y5;
    logic [3:0]  sv;
    logic [31:0] xs, xe;
    logic [4:0]  sv5;
    logic [39:0] xs5, xe5;
    int n_cmp, n_err;

    // Behavioural model state
    int m_top[4], m_mid[4], m_bot[4], m_en[4], m_side[4];
    int m_xl[4], m_xr[4], m_sl[4], m_sr[4], m_sb[4], m_accl[4], m_accr[4];
    int m_y;

    typedef struct {
        int tri_i; int word; logic [3:0] s; logic [31:0] wd; logic [31:0] exp;
    } wb_vec_t;
    typedef struct {
        int y; bit v0; int xs0; int xe0; bit v1; int xs1; int xe1;
    } scan_vec_t;

    tri_span_array #(.NUM_TRI(4), .COORD_W(8), .FRAC_W(8)) u_dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .wbs_cyc_i(cyc), .wbs_stb_i(stb & ~use5),
        .wbs_we_i(we), .wbs_sel_i(sel), .wbs_adr_i(adr[6:0]), .wbs_dat_i(dat),
        .wbs_ack_o(ack4), .wbs_dat_o(dat4), .frame_start(frame_start), .line_step(line_step),
        .y_o(y_o), .span_valid(sv), .x_start(xs), .x_end(xe)
    );

    tri_span_array #(.NUM_TRI(5), .COORD_W(8), .FRAC_W(8)) u_dut5 (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .wbs_cyc_i(cyc), .wbs_stb_i(stb & use5),
        .wbs_we_i(we), .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat),
        .wbs_ack_o(ack5), .wbs_dat_o(dat5), .frame_start(zero), .line_step(zero),
        .y_o(y5), .span_valid(sv5), .x_start(xs5), .x_end(xe5)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic wb(input bit which, input int tri_i, input int word, input bit w,
                      input logic [3:0] s, input logic [31:0] d, output logic [31:0] q);
        int  n;
        logic got;
        @(negedge clk);
        use5 = which;
        adr  = 8'((tri_i << 5) | (word << 2));
        cyc  = 1'b1; stb = 1'b1; we = w; sel = s; dat = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            got = which ? ack5 : ack4;
        end while (!got && n < 4);
        q = which ? dat5 : dat4;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        chk("wb_ack", got, 1);
    endtask

    task automatic model_frame();
        m_y = 0;
        for (int t = 0; t < 4; t++) begin
            m_accl[t] = m_xl[t];
            m_accr[t] = m_xr[t];
        end
    endtask

    task automatic model_step();
        for (int t = 0; t < 4; t++) begin
            if (m_en[t] != 0 && m_top[t] <= m_y && m_y < m_bot[t]) begin
                if (m_y < m_mid[t]) begin
                    m_accl[t] += m_sl[t]; m_accr[t] += m_sr[t];
                end else if (m_side[t] != 0) begin
                    m_accl[t] += m_sl[t]; m_accr[t] += m_sb[t];
                end else begin
                    m_accl[t] += m_sb[t]; m_accr[t] += m_sr[t];
                end
                m_accl[t] &= 'hFFFF;
                m_accr[t] &= 'hFFFF;
            end
        end
        m_y = (m_y + 1) % 256;
    endtask

    task automatic pulse(input bit fs, input bit ls);
        @(negedge clk);
        frame_start = fs; line_step = ls;
        @(negedge clk);
        frame_start = 1'b0; line_step = 1'b0;
        if (fs) model_frame();
        else if (ls) model_step();
    endtask

    task automatic prog(input int t, input int top, input int mid, input int bot, input int e,
                        input int sd, input int xl, input int xr, input int sl, input int sr,
                        input int sb);
        logic [31:0] q;
        wb(0, t, 0, 1, 4'hF, {16'(mid), 16'(top)}, q);
        wb(0, t, 1, 1, 4'hF, {14'd0, 1'(sd), 1'(e), 16'(bot)}, q);
        wb(0, t, 2, 1, 4'hF, {16'(xr), 16'(xl)}, q);
        wb(0, t, 3, 1, 4'hF, {16'(sr), 16'(sl)}, q);
        wb(0, t, 4, 1, 4'hF, {16'd0, 16'(sb)}, q);
        m_top[t] = top; m_mid[t] = mid; m_bot[t] = bot; m_en[t] = e; m_side[t] = sd;
        m_xl[t] = xl; m_xr[t] = xr; m_sl[t] = sl; m_sr[t] = sr; m_sb[t] = sb;
    endtask

    task automatic prog_rand(input int t);
        prog(t, int'($urandom_range(0, 12)), int'($urandom_range(0, 20)),
             int'($urandom_range(0, 20)), int'($urandom_range(0, 3) != 0),
             int'($urandom_range(0, 1)), int'($urandom_range(0, 65535)),
             int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
             int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)));
    endtask

    task automatic mcheck();
        chk("rnd_y", y_o, 64'(m_y));
        for (int t = 0; t < 4; t++) begin
            chk("rnd_valid", sv[t], 64'(m_en[t] != 0 && m_top[t] <= m_y && m_y <= m_bot[t]));
            chk("rnd_xs", xs[t*8 +: 8], 64'((m_accl[t] >> 8) & 255));
            chk("rnd_xe", xe[t*8 +: 8], 64'((m_accr[t] >> 8) & 255));
        end
    endtask

    initial begin
        wb_vec_t     wv[8];
        scan_vec_t   scan[7];
        logic [31:0] q;
        logic [3:0]  pat;
        int          op, t;

        wv[0] = '{2, 3, 4'b0101, 32'h12345678, 32'h00340078};
        wv[1] = '{2, 3, 4'b1010, 32'hAABBCCDD, 32'hAA34CC78};
        wv[2] = '{1, 1, 4'b1111, 32'hFFFFFFFF, 32'h000300FF};
        wv[3] = '{3, 0, 4'b1111, 32'h12345678, 32'h00340078};
        wv[4] = '{0, 6, 4'b1111, 32'hFFFFFFFF, 32'h00000000};
        wv[5] = '{0, 5, 4'b1111, 32'hFFFFFFFF, 32'h00000000};
        wv[6] = '{3, 4, 4'b1100, 32'hDEADBEEF, 32'h00000000};
        wv[7] = '{3, 4, 4'b0011, 32'hDEADBEEF, 32'h0000BEEF};

        scan[0] = '{0, 0, 10, 10, 1, 20, 20};
        scan[1] = '{1, 0, 10, 10, 1, 20, 21};
        scan[2] = '{2, 1, 10, 10, 1, 20, 23};
        scan[3] = '{3, 1,  9, 12, 1, 20, 22};
        scan[4] = '{4, 1,  8, 14, 1, 20, 21};
        scan[5] = '{5, 1,  7, 16, 0, 20, 21};
        scan[6] = '{6, 0,  7, 16, 0, 20, 21};

        n_cmp = 0; n_err = 0;
        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; use5 = 1'b0; zero = 1'b0;
        frame_start = 1'b0; line_step = 1'b0; sel = 4'h0; adr = '0; dat = '0;
        for (int i = 0; i < 4; i++) begin
            m_top[i] = 0; m_mid[i] = 0; m_bot[i] = 0; m_en[i] = 0; m_side[i] = 0;
            m_xl[i] = 0; m_xr[i] = 0; m_sl[i] = 0; m_sr[i] = 0; m_sb[i] = 0;
            m_accl[i] = 0; m_accr[i] = 0;
        end
        m_y = 0;
        repeat (3) @(negedge clk);
        chk("rst_ack", ack4, 0);
        chk("rst_dat", dat4, 0);
        chk("rst_y", y_o, 0);
        chk("rst_valid", sv, 0);
        chk("rst_xs", xs, 0);
        chk("rst_xe", xe, 0);
        rst_n = 1'b1;

        // Register map, byte lanes and field widths
        for (int i = 0; i < 8; i++) begin
            wb(0, wv[i].tri_i, wv[i].word, 1, wv[i].s, wv[i].wd, q);
            wb(0, wv[i].tri_i, wv[i].word, 0, 4'hF, 32'h0, q);
            chk("wb_readback", q, wv[i].exp);
        end

        // Out-of-range triangle on a five-channel instance
        wb(1, 5, 0, 1, 4'hF, 32'hFFFFFFFF, q);
        wb(1, 5, 0, 0, 4'hF, 32'h0, q);
        chk("wb_oor_read", q, 0);
        wb(1, 4, 0, 1, 4'hF, 32'h00070003, q);
        wb(1, 4, 0, 0, 4'hF, 32'h0, q);
        chk("wb_last_tri_read", q, 32'h00070003);

        // Held strobe is acked on alternate cycles
        @(negedge clk);
        use5 = 1'b0; adr = 8'h00; cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF;
        for (int i = 3; i >= 0; i--) begin
            @(negedge clk);
            pat[i] = ack4;
        end
        cyc = 1'b0; stb = 1'b0;
        chk("wb_back_to_back", pat, 4'b1010);

        // Scan of two triangles
        prog(0, 2, 5, 5, 1, 0, 'h0A00, 'h0A00, 'hFF00, 'h0200, 0);
        prog(1, 0, 2, 4, 1, 1, 'h1400, 'h1400, 0, 'h0180, 'hFF00);
        pulse(1, 0);
        for (int i = 0; i < 7; i++) begin
            if (i > 0) pulse(0, 1);
            chk("scan_y", y_o, 64'(scan[i].y));
            chk("scan_v0", sv[0], 64'(scan[i].v0));
            chk("scan_xs0", xs[7:0], 64'(scan[i].xs0));
            chk("scan_xe0", xe[7:0], 64'(scan[i].xe0));
            chk("scan_v1", sv[1], 64'(scan[i].v1));
            chk("scan_xs1", xs[15:8], 64'(scan[i].xs1));
            chk("scan_xe1", xe[15:8], 64'(scan[i].xe1));
        end

        // frame_start overrides a simultaneous line_step
        pulse(1, 0);
        repeat (3) pulse(0, 1);
        chk("sim_pre_y", y_o, 3);
        pulse(1, 1);
        chk("sim_y", y_o, 0);
        wb(0, 0, 5, 0, 4'hF, 32'h0, q);
        chk("sim_acc0", q, 32'h0A000A00);
        wb(0, 1, 5, 0, 4'hF, 32'h0, q);
        chk("sim_acc1", q, 32'h14001400);

        // Line counter wrap without reload
        repeat (255) pulse(0, 1);
        chk("wrap_y255", y_o, 255);
        pulse(0, 1);
        chk("wrap_y0", y_o, 0);
        chk("wrap_v0", sv[0], 0);
        chk("wrap_xs0", xs[7:0], 7);
        chk("wrap_xe0", xe[7:0], 16);
        chk("wrap_xe1", xe[15:8], 21);

        // Randomised traffic against the model
        for (int i = 0; i < 4; i++) prog_rand(i);
        pulse(1, 0);
        mcheck();
        for (int i = 0; i < 300; i++) begin
            op = int'($urandom_range(0, 9));
            if (op == 0) pulse(1, 0);
            else if (op == 1) pulse(1, 1);
            else if (op <= 6) pulse(0, 1);
            else pulse(0, 0);
            mcheck();
            if (i % 25 == 24) begin
                t = int'($urandom_range(0, 3));
                wb(0, t, 5, 0, 4'hF, 32'h0, q);
                chk("rnd_acc_rd", q, {16'(m_accr[t]), 16'(m_accl[t])});
                prog_rand(int'($urandom_range(0, 3)));
                mcheck();
            end
        end

        // Reset in the middle of a bus cycle and a scan
        @(negedge clk);
        use5 = 1'b0; adr = 8'h00; cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_ack", ack4, 0);
        chk("midrst_valid", sv, 0);
        chk("midrst_y", y_o, 0);
        chk("midrst_dat", dat4, 0);
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int tt = 0; tt < 4; tt++) begin
            for (int w = 0; w < 8; w++) begin
                wb(0, tt, w, 0, 4'hF, 32'h0, q);
                chk("midrst_readback", q, 0);
            end
        end
        pulse(0, 1);
        chk("midrst_no_span", sv, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
